// File: rtl/line_fetch_scheduler.sv
// Line fetch scheduler: pulls video lines from DDR3 in bursts into a two-slot
// ping-pong on-chip line buffer and tracks which slots hold a complete line.
module line_fetch_scheduler #(
  parameter int          LINE_WORDS  = 180,
  parameter int          MAX_BURST   = 16,
  parameter int          FRAME_LINES = 1080,
  parameter logic [21:0] FRAME_BASE  = 22'h0,
  parameter int          SLOT_STRIDE = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         line_req,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_read,
  output logic [21:0]  ddr3_emif_addr,
  output logic [4:0]   ddr3_emif_burst_count,
  input  logic         ddr3_emif_rddata_valid,
  input  logic [255:0] ddr3_emif_read_data,
  output logic         onchip_mem_write,
  output logic [12:0]  onchip_mem_addr,
  output logic [255:0] onchip_mem_write_data,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic [1:0]   slot_valid,
  output logic         rd_slot,
  output logic         busy,
  output logic         underrun
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           frame_act_q, frame_act_d;
  logic [15:0]    line_q, line_d;
  logic [15:0]    word_off_q, word_off_d;
  logic [4:0]     beats_q, beats_d;
  logic           wr_slot_q, wr_slot_d;
  logic           rd_slot_q, rd_slot_d;
  logic [1:0]     slot_valid_q, slot_valid_d;
  logic           read_q, read_d;
  logic [21:0]    addr_q, addr_d;
  logic [4:0]     burst_q, burst_d;
  logic           mwr_q, mwr_d;
  logic [12:0]    maddr_q, maddr_d;
  logic [255:0]   mdata_q, mdata_d;
  logic [31:0]    be_q, be_d;
  logic           underrun_q, underrun_d;
  logic           busy_q, busy_d;
  logic           fill_done;
  logic           restart;
  logic [12:0]    slot_base;

  function automatic logic [21:0] line_addr(input logic [15:0] line, input logic [15:0] off);
    return FRAME_BASE + 22'(line) * 22'(LINE_WORDS) + 22'(off);
  endfunction

  function automatic logic [4:0] burst_len(input logic [15:0] off);
    logic [15:0] rem;
    rem = 16'(LINE_WORDS) - off;
    return (rem > 16'(MAX_BURST)) ? 5'(MAX_BURST) : rem[4:0];
  endfunction

  assign slot_base = wr_slot_q ? 13'(SLOT_STRIDE) : 13'd0;

  always_comb begin
    state_d      = state_q;
    frame_act_d  = frame_act_q;
    line_d       = line_q;
    word_off_d   = word_off_q;
    beats_d      = beats_q;
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    slot_valid_d = slot_valid_q;
    read_d       = read_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    mwr_d        = 1'b0;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;
    be_d         = '0;
    underrun_d   = 1'b0;
    fill_done    = 1'b0;
    restart      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          restart = 1'b1;
        end else if (frame_act_q && (line_q < 16'(FRAME_LINES)) && !slot_valid_q[wr_slot_q]) begin
          state_d = REQ;
          read_d  = 1'b1;
          addr_d  = line_addr(line_q, word_off_q);
          burst_d = burst_len(word_off_q);
        end
      end
      REQ: begin
        if (start) begin
          restart = 1'b1;
        end else if (ddr3_emif_ready) begin
          state_d = DATA;
          read_d  = 1'b0;
          beats_d = burst_q;
        end
      end
      DATA: begin
        if (start) begin
          // Beats of the accepted burst are still in flight; swallow them first.
          if (beats_q == 5'd0) begin
            restart = 1'b1;
          end else begin
            state_d = DRAIN;
            if (ddr3_emif_rddata_valid) beats_d = beats_q - 5'd1;
          end
        end else if (beats_q != 5'd0) begin
          if (ddr3_emif_rddata_valid) begin
            mwr_d      = 1'b1;
            be_d       = '1;
            maddr_d    = slot_base + 13'(word_off_q);
            mdata_d    = ddr3_emif_read_data;
            word_off_d = word_off_q + 16'd1;
            beats_d    = beats_q - 5'd1;
          end
        end else if (word_off_q >= 16'(LINE_WORDS)) begin
          fill_done  = 1'b1;
          state_d    = IDLE;
          wr_slot_d  = ~wr_slot_q;
          word_off_d = '0;
          line_d     = line_q + 16'd1;
        end else begin
          state_d = REQ;
          read_d  = 1'b1;
          addr_d  = line_addr(line_q, word_off_q);
          burst_d = burst_len(word_off_q);
        end
      end
      DRAIN: begin
        if (beats_q == 5'd0) begin
          restart = 1'b1;
        end else if (ddr3_emif_rddata_valid) begin
          beats_d = beats_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d      = IDLE;
      frame_act_d  = 1'b1;
      slot_valid_d = '0;
      rd_slot_d    = 1'b0;
      wr_slot_d    = 1'b0;
      line_d       = '0;
      word_off_d   = '0;
      beats_d      = '0;
      read_d       = 1'b0;
    end else begin
      // Fill and consume touch independent slot bits, so both apply together.
      if (fill_done) slot_valid_d[wr_slot_q] = 1'b1;
      if (line_req) begin
        if (slot_valid_q[rd_slot_q]) begin
          slot_valid_d[rd_slot_q] = 1'b0;
          rd_slot_d               = ~rd_slot_q;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_act_q  <= 1'b0;
      line_q       <= '0;
      word_off_q   <= '0;
      beats_q      <= '0;
      wr_slot_q    <= 1'b0;
      rd_slot_q    <= 1'b0;
      slot_valid_q <= '0;
      read_q       <= 1'b0;
      addr_q       <= '0;
      burst_q      <= '0;
      mwr_q        <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
      be_q         <= '0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_act_q  <= frame_act_d;
      line_q       <= line_d;
      word_off_q   <= word_off_d;
      beats_q      <= beats_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      slot_valid_q <= slot_valid_d;
      read_q       <= read_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      mwr_q        <= mwr_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
      be_q         <= be_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
    end
  end

  assign ddr3_emif_read         = read_q;
  assign ddr3_emif_addr         = addr_q;
  assign ddr3_emif_burst_count  = burst_q;
  assign onchip_mem_write       = mwr_q;
  assign onchip_mem_addr        = maddr_q;
  assign onchip_mem_write_data  = mdata_q;
  assign onchip_mem_byte_enable = be_q;
  assign slot_valid             = slot_valid_q;
  assign rd_slot                = rd_slot_q;
  assign busy                   = busy_q;
  assign underrun               = underrun_q;

endmodule
